// File: rtl/exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl
// Description : Run-control and next-PC sequencer for the single-cycle core.
//               Resolves branch/jump targets, gates register-file writes and
//               sequences IDLE/RUN/HALT/ERR with bring-up counters.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_ctrl #(
  parameter int MAX_INSTR = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             clear,
  input  logic             step_mode,
  input  logic             step,
  input  logic [31:0]      pc,
  input  logic [6:0]       opcode,
  input  logic [3:0]       func,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic [31:0]      imm,
  input  logic             hata,
  input  logic             we_in,
  output logic             pc_update,
  output logic [31:0]      pc_new,
  output logic             we_en,
  output logic             running,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [6:0]       c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]       c_OP_JALR   = 7'b1100111;
  localparam logic [6:0]       c_OP_ECALL  = 7'b1110011;
  localparam logic [1:0]       c_ERR_NONE  = 2'd0;
  localparam logic [1:0]       c_ERR_DEC   = 2'd1;
  localparam logic [1:0]       c_ERR_ALIGN = 2'd2;
  localparam logic [1:0]       c_ERR_WDOG  = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_WD_LIMIT  = CNT_W'(MAX_INSTR);
  localparam logic             c_WD_EN     = (MAX_INSTR != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instr;

  logic             w_is_br;
  logic             w_is_jal;
  logic             w_is_jalr;
  logic             w_is_ecall;
  logic             w_br_valid;
  logic             w_br_taken;
  logic [31:0]      w_sum_pc;
  logic [31:0]      w_sum_jalr;
  logic [31:0]      w_target;
  logic             w_redirect;
  logic             w_misalign;
  logic             w_dec_err;
  logic             w_commit;
  logic             w_retire;
  logic [CNT_W-1:0] w_cycle_inc;
  logic [CNT_W-1:0] w_instr_inc;
  logic             w_wd_hit;
  logic             w_unused;

  assign w_is_br    = (opcode == c_OP_BRANCH);
  assign w_is_jal   = (opcode == c_OP_JAL);
  assign w_is_jalr  = (opcode == c_OP_JALR);
  assign w_is_ecall = (opcode == c_OP_ECALL);

  // Branch condition evaluation; unsupported conditions flag a decode error
  always_comb begin
    w_br_valid = 1'b1;
    w_br_taken = 1'b0;
    case (func[2:0])
      3'b000:  w_br_taken = (rs1_data == rs2_data);
      3'b001:  w_br_taken = (rs1_data != rs2_data);
      3'b100:  w_br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  w_br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  w_br_taken = (rs1_data <  rs2_data);
      3'b111:  w_br_taken = (rs1_data >= rs2_data);
      default: w_br_valid = 1'b0;
    endcase
  end

  // Target generation: PC-relative for branch/JAL, register-relative for JALR
  assign w_sum_pc   = pc + imm;
  assign w_sum_jalr = rs1_data + imm;
  assign w_target   = w_is_jalr ? {w_sum_jalr[31:1], 1'b0} : w_sum_pc;
  assign w_redirect = w_is_jal | w_is_jalr | (w_is_br & w_br_valid & w_br_taken);
  assign w_misalign = w_redirect & (w_target[1:0] != 2'b00);
  assign w_dec_err  = w_is_br & ~w_br_valid;

  // A commit slot exists; the instruction retires only if nothing faults it
  assign w_commit = (r_state == S_RUN) & (~step_mode | step) & ~hata & ~abort;
  assign w_retire = w_commit & ~w_is_ecall & ~w_dec_err & ~w_misalign;

  assign w_cycle_inc = (r_cycle == c_CNT_MAX) ? r_cycle : (r_cycle + c_CNT_ONE);
  assign w_instr_inc = (r_instr == c_CNT_MAX) ? r_instr : (r_instr + c_CNT_ONE);
  // Fire only on the transition onto the limit so a saturated count cannot retrigger
  assign w_wd_hit    = c_WD_EN & (w_instr_inc == c_WD_LIMIT) & (r_instr != c_WD_LIMIT);

  // Bits not needed by any decision; kept visible to avoid dangling logic
  assign w_unused = ^{func[3], w_sum_jalr[0]};

  // Fetch control and write gating: hold unless an instruction retires
  always_comb begin
    pc_update = 1'b1;
    pc_new    = pc;
    we_en     = 1'b0;
    if (w_retire) begin
      pc_update = w_redirect;
      pc_new    = w_redirect ? w_target : pc;
      we_en     = we_in;
    end
  end

  // Run-control state machine with error code and bring-up counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_err_code <= c_ERR_NONE;
      r_cycle    <= '0;
      r_instr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_cycle <= '0;
            r_instr <= '0;
          end else if (start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_cycle <= w_cycle_inc;
          if (hata) begin
            r_state    <= S_ERR;
            r_err_code <= c_ERR_DEC;
          end else if (abort) begin
            r_state <= S_IDLE;
          end else if (w_commit) begin
            if (w_dec_err) begin
              r_state    <= S_ERR;
              r_err_code <= c_ERR_DEC;
            end else if (w_is_ecall) begin
              r_state <= S_HALT;
            end else if (w_misalign) begin
              r_state    <= S_ERR;
              r_err_code <= c_ERR_ALIGN;
            end else begin
              r_instr <= w_instr_inc;
              if (w_wd_hit) begin
                r_state    <= S_ERR;
                r_err_code <= c_ERR_WDOG;
              end
            end
          end
        end
        S_HALT, S_ERR: begin
          if (clear) begin
            r_state    <= S_IDLE;
            r_err_code <= c_ERR_NONE;
            r_cycle    <= '0;
            r_instr    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign running     = (r_state == S_RUN);
  assign halted      = (r_state == S_HALT);
  assign err         = (r_state == S_ERR);
  assign err_code    = r_err_code;
  assign cycle_count = r_cycle;
  assign instr_count = r_instr;

endmodule
`default_nettype wire
